// File: rtl/instr_queue_if.sv
// Fetch-to-decode instruction queue bus.
// slave  : queue side (takes fetcher push, flush and decode ready; returns head entry and status)
// master : environment side (fetcher, control unit and decode as seen by the queue)
interface instr_queue_if #(
  parameter int unsigned bits  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic [bits-1:0] in_instr;
  logic [bits-1:0] in_pc;
  logic            in_ready;
  logic            fetch_en;
  logic            flush;
  logic            out_valid;
  logic [bits-1:0] out_instr;
  logic [bits-1:0] out_pc;
  logic            dec_ready;
  logic [CW-1:0]   count;
  logic            overflow;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, dec_ready,
    output in_ready, fetch_en, out_valid, out_instr, out_pc, count, overflow
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, dec_ready,
    input  in_ready, fetch_en, out_valid, out_instr, out_pc, count, overflow
  );
endinterface

// File: rtl/instr_queue.sv
// Instruction queue between fetcher and decode.
// Buffers up to DEPTH {instr, pc} pairs in FIFO order with a first-word-fall-through
// head, throttles the fetcher via fetch_en, and drops all contents on flush.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   q    - instr_queue_if.slave: push (in_*), pop (out_*, dec_ready), flush,
//          fetch_en, count and sticky overflow
module instr_queue #(
  parameter int unsigned bits  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  instr_queue_if.slave q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [bits-1:0] NOP = bits'(32'h0000_0013);

  logic [bits-1:0] instr_mem [DEPTH];
  logic [bits-1:0] pc_mem    [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_n;
  logic          in_ready_q;
  logic          fetch_en_q;
  logic          out_valid_q;
  logic          overflow_q;
  logic          push_c;
  logic          pop_c;

  // Flush overrides both handshakes in the same cycle.
  assign push_c = q.in_valid & in_ready_q & ~q.flush;
  assign pop_c  = out_valid_q & q.dec_ready & ~q.flush;

  // Next occupancy.
  always_comb begin
    count_n = count_q;
    if (q.flush) begin
      count_n = '0;
    end else if (push_c && !pop_c) begin
      count_n = count_q + CW'(1);
    end else if (pop_c && !push_c) begin
      count_n = count_q - CW'(1);
    end
  end

  // Pointers, occupancy and status flags; flags are precomputed from next count
  // so they stay registered yet track count exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      fetch_en_q  <= 1'b1;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q <= count_n;
      if (q.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PW'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      end
      in_ready_q  <= (count_n != CW'(DEPTH));
      // One slot stays reserved for the response already in flight.
      fetch_en_q  <= (count_n <= CW'(DEPTH - 2));
      out_valid_q <= (count_n != '0);
      // Any word offered while full is lost, flush or not; sticky until reset.
      if (q.in_valid && !in_ready_q) overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem[wr_ptr] <= q.in_instr;
      pc_mem[wr_ptr]    <= q.in_pc;
    end
  end

  assign q.in_ready  = in_ready_q;
  assign q.fetch_en  = fetch_en_q;
  assign q.out_valid = out_valid_q;
  assign q.count     = count_q;
  assign q.overflow  = overflow_q;
  assign q.out_instr = out_valid_q ? instr_mem[rd_ptr] : NOP;
  assign q.out_pc    = out_valid_q ? pc_mem[rd_ptr]    : '0;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_instr_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  logic clk;
  logic rst;

  instr_queue_if #(.bits(32), .DEPTH(DEPTH)) q ();

  instr_queue #(.bits(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents of the queue, and transfers the model expects decode to see.
  item_t mq[$];
  item_t exp_q[$];
  bit    model_ovf = 1'b0;

  // Expected observable state for the current cycle (written by driver, read by monitor).
  int    exp_count    = 0;
  bit    exp_in_ready = 1'b1;
  bit    exp_fetch_en = 1'b1;
  bit    exp_valid    = 1'b0;
  bit    exp_ovf      = 1'b0;
  item_t exp_head     = '{instr: NOP, pc: 32'h0};

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    q.in_valid  = 1'b0;
    q.in_instr  = 32'h0;
    q.in_pc     = 32'h0;
    q.flush     = 1'b0;
    q.dec_ready = 1'b0;
  endtask

  // One cycle of stimulus: record what the queue should show now, drive inputs,
  // then advance the model to the state after the coming edge.
  task automatic step(input bit iv, input logic [31:0] instr, input logic [31:0] pc,
                      input bit fl, input bit dr);
    int cnt;
    bit full;
    @(posedge clk);
    #2;
    cnt          = mq.size();
    full         = (cnt == DEPTH);
    exp_count    = cnt;
    exp_in_ready = !full;
    exp_fetch_en = (cnt <= DEPTH - 2);
    exp_valid    = (cnt != 0);
    exp_ovf      = model_ovf;
    exp_head     = (cnt != 0) ? mq[0] : '{instr: NOP, pc: 32'h0};
    q.in_valid   = iv;
    q.in_instr   = instr;
    q.in_pc      = pc;
    q.flush      = fl;
    q.dec_ready  = dr;
    if (iv && full) model_ovf = 1'b1;
    if (fl) begin
      mq.delete();
    end else begin
      if (dr && cnt != 0) exp_q.push_back(mq.pop_front());
      if (iv && !full) mq.push_back('{instr: instr, pc: pc});
    end
  endtask

  // Monitor: state checks each cycle, transfer checks on every accepted pop,
  // and immediate reset-value checks on reset assertion.
  initial begin
    item_t got;
    item_t want;
    forever begin
      @(negedge clk or negedge rst);
      if (done) begin
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (!rst) begin
        #1;
        chk("rst_out_valid", 64'(q.out_valid), 64'd0);
        chk("rst_out_instr", 64'(q.out_instr), 64'(NOP));
        chk("rst_out_pc",    64'(q.out_pc),    64'd0);
        chk("rst_in_ready",  64'(q.in_ready),  64'd1);
        chk("rst_fetch_en",  64'(q.fetch_en),  64'd1);
        chk("rst_count",     64'(q.count),     64'd0);
        chk("rst_overflow",  64'(q.overflow),  64'd0);
      end else begin
        chk("count",     64'(q.count),     64'(exp_count));
        chk("in_ready",  64'(q.in_ready),  64'(exp_in_ready));
        chk("fetch_en",  64'(q.fetch_en),  64'(exp_fetch_en));
        chk("out_valid", 64'(q.out_valid), 64'(exp_valid));
        chk("overflow",  64'(q.overflow),  64'(exp_ovf));
        chk("head_instr", 64'(q.out_instr), 64'(exp_head.instr));
        chk("head_pc",    64'(q.out_pc),    64'(exp_head.pc));
        if (q.out_valid && q.dec_ready && !q.flush) begin
          got = '{instr: q.out_instr, pc: q.out_pc};
          if (exp_q.size() == 0) begin
            chk("xfer_unexpected", 64'(got), 64'd0);
          end else begin
            want = exp_q.pop_front();
            chk("xfer_instr", 64'(got.instr), 64'(want.instr));
            chk("xfer_pc",    64'(got.pc),    64'(want.pc));
          end
        end
      end
    end
  end

  // Driver.
  initial begin
    logic [31:0] rpc;
    idle_inputs();
    rst = 1'b0;
    #22 rst = 1'b1;

    // Fill with decode stalled.
    for (int k = 0; k < 4; k++) step(1'b1, 32'h0010_0093 + 32'(k), 32'(4 * k), 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    // Drain in order.
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    // Sustained push+pop across pointer wrap.
    for (int k = 0; k < 11; k++) step(1'b1, 32'h0020_0000 + 32'(k), 32'h100 + 32'(4 * k), 1'b0, 1'b1);
    // Build to three entries, then flush with a push and pop pending.
    for (int k = 0; k < 2; k++) step(1'b1, 32'h0030_0000 + 32'(k), 32'h200 + 32'(4 * k), 1'b0, 1'b0);
    step(1'b1, 32'h0BAD_0001, 32'h300, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    // Fill, offer a word while full, then flush: overflow must survive.
    for (int k = 0; k < 4; k++) step(1'b1, 32'h0040_0000 + 32'(k), 32'h400 + 32'(4 * k), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 32'h500, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    // Two entries, then asynchronous reset mid-cycle.
    for (int k = 0; k < 2; k++) step(1'b1, 32'h0050_0000 + 32'(k), 32'h600 + 32'(4 * k), 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle_inputs();
    mq.delete();
    exp_q.delete();
    model_ovf    = 1'b0;
    exp_count    = 0;
    exp_in_ready = 1'b1;
    exp_fetch_en = 1'b1;
    exp_valid    = 1'b0;
    exp_ovf      = 1'b0;
    exp_head     = '{instr: NOP, pc: 32'h0};
    @(posedge clk);
    #3;
    rst = 1'b1;
    step(1'b1, 32'h0060_0013, 32'h40, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic.
    rpc = 32'h1000;
    for (int k = 0; k < 400; k++) begin
      bit iv;
      iv = ($urandom_range(0, 9) < 7);
      step(iv, $urandom, rpc, ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 6));
      if (iv) rpc = rpc + 32'd4;
    end

    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("FAIL monitor_timeout: monitor did not finish");
    $fatal(1, "monitor did not finish");
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction queue between the fetcher and the decode stage. Captures each instruction returned by the fetcher together with its PC, buffers up to `DEPTH` entries in FIFO order, and presents the oldest entry to decode with a valid/ready handshake. Throttles the fetcher through `fetch_en` and discards all buffered instructions on a control-flow `flush` from the Control Unit.

## Interface
- `bits`, 32, data and address width.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
- `in_valid`  in  1  fetcher has a returned instruction this cycle.
- `in_instr`  in  `bits`  instruction word from the fetcher.
- `in_pc`  in  `bits`  PC of `in_instr`.
- `in_ready`  out  1  queue can accept a push this cycle.
- `fetch_en`  out  1  fetcher may issue a new memory request; drives the PC enable.
- `flush`  in  1  taken branch/jump; discard all contents.
- `out_valid`  out  1  head entry is valid.
- `out_instr`  out  `bits`  head instruction; NOP `0x00000013` when empty.
- `out_pc`  out  `bits`  head PC; `0` when empty.
- `dec_ready`  in  1  decode accepts the head entry this cycle.
- `count`  out  log2(`DEPTH`)+1  current occupancy.
- `overflow`  out  1  sticky flag: a push arrived while full.

## Operation
- Storage: `DEPTH`-entry arrays for instruction and PC. Write pointer, read pointer (log2(`DEPTH`) bits, wrap naturally modulo `DEPTH`), and registered occupancy counter.
- `full` = (`count` == `DEPTH`). `empty` = (`count` == 0).
- push = `in_valid` & `in_ready`; `in_ready` = !`full`.
- pop = `out_valid` & `dec_ready`; `out_valid` = !`empty`.
- Simultaneous push and pop:
  - Both pointers advance; `count` is unchanged.
  - When full, pop does not enable push in the same cycle (`in_ready` depends on registered `count` only).
- `in_valid` while full: the word is dropped, pointers are unchanged, and `overflow` sets. `overflow` clears only on reset.
- `fetch_en` = (`count` ≤ `DEPTH`-2). This reserves one slot for the response already in flight in the fetcher.
- `flush` has the highest priority:
  - Next edge sets both pointers and `count` to 0.
  - Any push and pop in the same cycle are ignored.
  - `overflow` is unaffected.
- Read path is first-word-fall-through. `out_instr`/`out_pc` are combinational from the head entry when non-empty, otherwise NOP and 0.
- Occupancy states: EMPTY (`count`=0), PARTIAL, FULL (`count`=`DEPTH`). Transitions move by at most ±1 per cycle, except `flush`, which goes to EMPTY from any state.

## Timing
- Reset values (asynchronous, immediately on `rst`=0):
  - pointers and `count` = 0, `overflow` = 0
  - `out_valid` = 0, `out_instr` = `0x00000013`, `out_pc` = 0
  - `in_ready` = 1, `fetch_en` = 1
- Latency:
  - A word pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N (0-cycle fall-through once written).
  - Minimum fetcher-to-decode latency is 1 edge.
- Throughput: 1 push and 1 pop per cycle, sustained.
- `count`, `in_ready`, `fetch_en` and `out_valid` update one edge after the causing event.
- Reset mid-operation: all contents are lost. The first push after release lands at entry 0.
- Storage arrays are not reset; reads of them are masked by `empty`.

## Test plan
- Reset, then 4 pushes (PC `0x0`,`0x4`,`0x8`,`0xC`; instr `0x00100093`+k) with `dec_ready`=0:
  - `count` = 4, `in_ready` = 0.
  - `fetch_en` drops after the 3rd push.
  - Head = PC `0x0`.
- From full, raise `dec_ready` for 4 cycles:
  - Pops return PCs `0x0`..`0xC` in order.
  - Then `out_valid` = 0, `out_instr` = `0x00000013`, `out_pc` = 0.
- Steady stream with `in_valid`=`dec_ready`=1 for 10 cycles (wrap-around):
  - `count` stays 1.
  - Every PC appears in order exactly once.
  - Pointers wrap past `DEPTH`.
- `flush`=1 with `count`=3 while `in_valid`=1 and `dec_ready`=1:
  - Next cycle `count` = 0, `out_valid` = 0.
  - The pushed word is absent.
  - `fetch_en` = 1.
- Full queue plus `in_valid`=1 (instr `0xDEADBEEF`):
  - `overflow` = 1 and stays set after `flush`.
  - `0xDEADBEEF` never appears on `out_instr`.
- Assert `rst`=0 asynchronously mid-cycle with `count`=2:
  - Outputs immediately take their reset values.
  - After release, push PC `0x40` → head PC `0x40`.
